// File: rtl/tri_eccgen_buf.sv
`default_nettype none
// tri_eccgen_buf -- 64b SEC-DED write-side encoder with a 2-entry valid/ready buffer and one-shot error injector.
// Rev 1.0
module tri_eccgen_buf #(
  parameter int REGSIZE = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [0:REGSIZE-1] in_data,
  input  logic               inj_arm,
  input  logic [6:0]         inj_pos,
  input  logic               inj_dbl,
  output logic               inj_pend,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [0:REGSIZE-1] out_data,
  output logic [0:7]         out_ecc,
  output logic               out_inj
);

  if (REGSIZE != 64) begin : g_bad_regsize
    $error("tri_eccgen_buf: REGSIZE must be 64");
  end

  localparam logic [7:0] C_COL [64] = '{
    8'hE0, 8'hD0, 8'hB0, 8'h70, 8'hC8, 8'hA8, 8'h68, 8'h98,
    8'h58, 8'h38, 8'hF8, 8'hC4, 8'hA4, 8'h64, 8'h94, 8'h54,
    8'h34, 8'hF4, 8'h8C, 8'h4C, 8'h2C, 8'hEC, 8'h1C, 8'hDC,
    8'hBC, 8'h7C, 8'hC2, 8'hA2, 8'h62, 8'h92, 8'h52, 8'h32,
    8'hF2, 8'h8A, 8'h4A, 8'h2A, 8'hEA, 8'h1A, 8'hDA, 8'hBA,
    8'h7A, 8'h86, 8'h46, 8'h26, 8'hE6, 8'h16, 8'hD6, 8'hB6,
    8'h76, 8'h0E, 8'hCE, 8'hAE, 8'h6E, 8'h9E, 8'h5E, 8'h3E,
    8'hFE, 8'hC1, 8'hA1, 8'h61, 8'h91, 8'h51, 8'h31, 8'hF1
  };
  localparam logic [6:0] C_LAST_POS = 7'd71;

  typedef enum logic {INJ_IDLE, INJ_ARMED} inj_state_e;

  typedef struct packed {
    logic [0:REGSIZE-1] data;
    logic [0:7]         ecc;
    logic               inj;
  } entry_t;

  inj_state_e        inj_state_q;
  logic [6:0]        inj_pos_q;
  logic              inj_dbl_q;
  logic [1:0]        cnt_q, cnt_d;
  entry_t            head_q, head_d, skid_q, skid_d;

  logic [0:7]         w_ecc;
  logic [0:REGSIZE+7] w_cw, w_mask;
  logic [6:0]         w_pos2;
  entry_t             w_new;
  logic               w_push, w_pop;

  // Check bit j is column bit (7-j); ecc[0] is the column MSB.
  always_comb begin
    w_ecc = '0;
    for (int i = 0; i < REGSIZE; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (C_COL[i][7-j]) w_ecc[j] = w_ecc[j] ^ in_data[i];
      end
    end
  end

  always_comb begin
    w_cw   = {in_data, w_ecc};
    w_mask = '0;
    w_pos2 = (inj_pos_q == C_LAST_POS) ? 7'd0 : inj_pos_q + 7'd1;
    if (inj_state_q == INJ_ARMED) begin
      w_mask[inj_pos_q] = 1'b1;
      if (inj_dbl_q) w_mask[w_pos2] = 1'b1;
    end
    w_new.data = w_cw[0:REGSIZE-1] ^ w_mask[0:REGSIZE-1];
    w_new.ecc  = w_cw[REGSIZE:REGSIZE+7] ^ w_mask[REGSIZE:REGSIZE+7];
    w_new.inj  = (inj_state_q == INJ_ARMED);
  end

  assign in_rdy   = ~rst & (cnt_q != 2'd2);
  assign out_val  = (cnt_q != 2'd0);
  assign out_data = head_q.data;
  assign out_ecc  = head_q.ecc;
  assign out_inj  = head_q.inj;
  assign inj_pend = (inj_state_q == INJ_ARMED);

  assign w_push = in_val & in_rdy;
  assign w_pop  = out_val & out_rdy;

  // head_q always presents the oldest beat; skid_q is only occupied at count 2.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    cnt_d  = cnt_q;
    if (w_pop) begin
      if (cnt_q == 2'd2)  head_d = skid_q;
      else if (w_push)    head_d = w_new;
    end else if (w_push) begin
      if (cnt_q == 2'd0)  head_d = w_new;
      else                skid_d = w_new;
    end
    if (w_push && !w_pop)      cnt_d = cnt_q + 2'd1;
    else if (w_pop && !w_push) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  // The beat accepted in the arm cycle is not injected: state is still IDLE then.
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_state_q <= INJ_IDLE;
      inj_pos_q   <= 7'd0;
      inj_dbl_q   <= 1'b0;
    end else begin
      case (inj_state_q)
        INJ_IDLE: begin
          if (inj_arm && (inj_pos <= C_LAST_POS)) begin
            inj_state_q <= INJ_ARMED;
            inj_pos_q   <= inj_pos;
            inj_dbl_q   <= inj_dbl;
          end
        end
        INJ_ARMED: begin
          if (w_push) inj_state_q <= INJ_IDLE;
        end
        default: inj_state_q <= INJ_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tri_eccgen_buf.sv
`default_nettype none
// tb_tri_eccgen_buf -- randomized and directed checks against a queue-based reference model.
// Rev 1.0
module tb_tri_eccgen_buf;

  logic        clk = 1'b0;
  logic        rst, in_val, in_rdy, inj_arm, inj_dbl, inj_pend, out_val, out_rdy, out_inj;
  logic [0:63] in_data, out_data;
  logic [6:0]  inj_pos;
  logic [0:7]  out_ecc;

  tri_eccgen_buf #(.REGSIZE(64)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
    .inj_arm(inj_arm), .inj_pos(inj_pos), .inj_dbl(inj_dbl), .inj_pend(inj_pend),
    .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .out_ecc(out_ecc),
    .out_inj(out_inj)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] COL [64] = '{
    8'hE0, 8'hD0, 8'hB0, 8'h70, 8'hC8, 8'hA8, 8'h68, 8'h98,
    8'h58, 8'h38, 8'hF8, 8'hC4, 8'hA4, 8'h64, 8'h94, 8'h54,
    8'h34, 8'hF4, 8'h8C, 8'h4C, 8'h2C, 8'hEC, 8'h1C, 8'hDC,
    8'hBC, 8'h7C, 8'hC2, 8'hA2, 8'h62, 8'h92, 8'h52, 8'h32,
    8'hF2, 8'h8A, 8'h4A, 8'h2A, 8'hEA, 8'h1A, 8'hDA, 8'hBA,
    8'h7A, 8'h86, 8'h46, 8'h26, 8'hE6, 8'h16, 8'hD6, 8'hB6,
    8'h76, 8'h0E, 8'hCE, 8'hAE, 8'h6E, 8'h9E, 8'h5E, 8'h3E,
    8'hFE, 8'hC1, 8'hA1, 8'h61, 8'h91, 8'h51, 8'h31, 8'hF1
  };

  typedef struct {
    logic [0:63] d;
    logic [0:7]  e;
    logic        inj;
    int          kind;   // 0 clean, 1 single (at pos), 2 uncorrectable
    int          pos;
  } beat_t;

  beat_t       q[$];
  int          n_chk = 0, n_pass = 0;
  int          n_pops = 0, n_pushes = 0;
  bit          m_armed = 0, m_dbl = 0, last_push = 0;
  int          m_pos = 0;
  logic [0:63] lp_data;
  logic [0:7]  lp_ecc;
  logic        lp_inj;
  int          lp_kind, lp_pos;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [0:7] ref_ecc(input logic [0:63] d);
    logic [0:7] e = '0;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 8; j++)
        if ((COL[i] & (8'h80 >> j)) != 8'h00) e[j] = e[j] ^ d[i];
    return e;
  endfunction

  // Read-side checker: classify a received codeword by its syndrome.
  task automatic classify(input logic [0:63] d, input logic [0:7] e, output int kind, output int pos);
    logic [7:0] syn = ref_ecc(d) ^ e;
    kind = (syn == 8'h00) ? 0 : 2;
    pos  = -1;
    for (int i = 0; i < 64; i++) if (syn != 0 && COL[i] == syn) begin kind = 1; pos = i; end
    for (int j = 0; j < 8; j++)  if (syn != 0 && (8'h80 >> j) == syn) begin kind = 1; pos = 64 + j; end
  endtask

  task automatic step();
    beat_t b;
    bit    armed0, push, pop;
    logic [0:71] cw;
    int    k, p;
    @(negedge clk);
    last_push = 0;
    if (rst) begin
      chk("rst_in_rdy", in_rdy, 0);
      q.delete();
      m_armed = 0;
    end else begin
      chk("in_rdy", in_rdy, q.size() != 2);
      chk("out_val", out_val, q.size() != 0);
      chk("inj_pend", inj_pend, m_armed);
      pop  = out_rdy && q.size() != 0;
      push = in_val && q.size() != 2;
      if (pop) begin
        b = q.pop_front();
        chk("out_data", out_data, b.d);
        chk("out_ecc", out_ecc, b.e);
        chk("out_inj", out_inj, b.inj);
        classify(out_data, out_ecc, k, p);
        chk("chk_kind", k, b.kind);
        if (b.kind == 1) chk("chk_pos", p, b.pos);
        lp_data = out_data; lp_ecc = out_ecc; lp_inj = out_inj; lp_kind = k; lp_pos = p;
        n_pops++;
      end
      armed0 = m_armed;
      if (push) begin
        b.d = in_data; b.e = ref_ecc(in_data); b.inj = 0; b.kind = 0; b.pos = -1;
        if (m_armed) begin
          cw = {b.d, b.e};
          cw[m_pos] = ~cw[m_pos];
          if (m_dbl) cw[(m_pos + 1) % 72] = ~cw[(m_pos + 1) % 72];
          b.d = cw[0:63]; b.e = cw[64:71]; b.inj = 1;
          b.kind = m_dbl ? 2 : 1; b.pos = m_pos;
          m_armed = 0;
        end
        q.push_back(b);
        n_pushes++;
        last_push = 1;
      end
      if (!armed0 && inj_arm && inj_pos <= 7'd71) begin
        m_armed = 1; m_pos = int'(inj_pos); m_dbl = inj_dbl;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_one(input logic [0:63] d);
    in_val = 1; in_data = d;
    for (int t = 0; t < 8 && !last_push; t++) step();
    chk("send_accept", last_push, 1);
    in_val = 0;
    last_push = 0;
  endtask

  task automatic arm(input int pos, input bit dbl);
    inj_arm = 1; inj_pos = 7'(pos); inj_dbl = dbl;
    step();
    inj_arm = 0;
  endtask

  logic [0:63] d;
  logic [7:0]  enc_exp [4] = '{8'h00, 8'hE0, 8'hF1, 8'h32};
  int          enc_bit [4] = '{-1, 0, 63, 31};
  int          p0, c0, cyc;

  initial begin
    rst = 1; in_val = 0; out_rdy = 0; inj_arm = 0; inj_pos = 0; inj_dbl = 0; in_data = '0;
    @(posedge clk); #1;
    step();
    rst = 0;
    step();
    chk("rst_data", out_data, 0);
    chk("rst_ecc", out_ecc, 0);
    chk("rst_inj", out_inj, 0);

    // directed encode vectors, held on the output with out_rdy low
    for (int v = 0; v < 4; v++) begin
      d = '0;
      if (enc_bit[v] >= 0) d[enc_bit[v]] = 1'b1;
      out_rdy = 0;
      send_one(d);
      step();
      chk("enc_ecc", out_ecc, enc_exp[v]);
      chk("enc_inj", out_inj, 0);
      out_rdy = 1;
      step();
    end

    // backpressure: A,B fill the buffer, C waits
    out_rdy = 0;
    in_val = 1; in_data = {32'hAAAA_0001, 32'h1234_5678}; step();
    in_data = {32'hBBBB_0002, 32'h8765_4321}; step();
    in_data = {32'hCCCC_0003, 32'h0F0F_F0F0}; step();
    chk("bp_rdy", in_rdy, 0);
    step();
    chk("bp_rdy_hold", in_rdy, 0);
    out_rdy = 1;
    p0 = n_pops;
    for (int t = 0; t < 3; t++) begin
      step();
      if (last_push) in_val = 0;
    end
    chk("bp_pops", n_pops - p0, 3);
    in_val = 0;

    // throughput: 100 back-to-back beats
    p0 = n_pops; c0 = n_pushes;
    out_rdy = 1;
    for (int t = 0; t < 100; t++) begin
      in_val = 1; in_data = {$urandom, $urandom};
      step();
    end
    in_val = 0;
    step();
    chk("tp_pushes", n_pushes - c0, 100);
    chk("tp_pops", n_pops - p0, 100);

    // random traffic with random backpressure
    c0 = n_pushes; cyc = 0;
    while (n_pushes - c0 < 10000 && cyc < 40000) begin
      in_val  = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      in_data = {$urandom, $urandom};
      step();
      cyc++;
    end
    chk("rand_done", (n_pushes - c0) >= 10000, 1);
    in_val = 0; out_rdy = 1;
    for (int t = 0; t < 4; t++) step();
    chk("drain_val", out_val, 0);

    // injection: single flip at data[5]
    arm(5, 0);
    chk("inj_armed", inj_pend, 1);
    send_one('0);
    step();
    chk("inj1_data", lp_data, 64'h0400_0000_0000_0000);
    chk("inj1_ecc", lp_ecc, 8'h00);
    chk("inj1_inj", lp_inj, 1);
    chk("inj1_sbe", lp_kind, 1);
    chk("inj1_pos", lp_pos, 5);

    // injection: double flip wrapping ecc[7] -> data[0]
    arm(71, 1);
    send_one('0);
    step();
    chk("inj2_data", lp_data, 64'h8000_0000_0000_0000);
    chk("inj2_ecc", lp_ecc, 8'h01);
    chk("inj2_ue", lp_kind, 2);

    // out-of-range position is ignored; arm-cycle beat stays clean
    arm(100, 0);
    chk("inj_ignored", inj_pend, 0);
    inj_arm = 1; inj_pos = 7'd66; inj_dbl = 0; in_val = 1; in_data = {$urandom, $urandom};
    step();
    inj_arm = 0;
    send_one({$urandom, $urandom});
    step(); step();

    // reset with a full buffer and an armed injector
    out_rdy = 0;
    send_one({$urandom, $urandom});
    send_one({$urandom, $urandom});
    arm(10, 1);
    chk("pre_rst_rdy", in_rdy, 0);
    rst = 1;
    step();
    rst = 0;
    step();
    chk("rst6_val", out_val, 0);
    chk("rst6_pend", inj_pend, 0);
    chk("rst6_rdy", in_rdy, 1);
    out_rdy = 1;
    send_one(64'hDEAD_BEEF_0123_4567);
    step();
    chk("rst6_fresh", lp_data, 64'hDEAD_BEEF_0123_4567);
    chk("rst6_inj", lp_inj, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
